usr_deserializer: RTL and testbench

- Serial-to-parallel receiver: the far end of a link driven by the universal shift register's shift-out path.
- Collects WIDTH serial bits, MSB-first or LSB-first, into a parallel word.
- Presents each completed word through a one-entry valid/ready output buffer, so a downstream consumer can stall without losing the word being assembled.

---
 rtl/usr_pkg.sv | 13 +
 rtl/usr_deserializer_if.sv | 28 ++
 rtl/usr_out_buf.sv | 55 +++++
 rtl/usr_deserializer.sv | 101 ++++++++++
 tb/tb_usr_deserializer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register link (rx and tx control).
// Contents: shift-direction encodings and the deserializer assembly FSM state type.
package usr_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_deserializer_if.sv
// Bus bundle between a serial source/parallel consumer and usr_deserializer.
// master: drives serial input, direction, frame marker, ready and overrun clear.
// slave : drives the buffered word, its valid flag, sticky overrun and bit count.
interface usr_deserializer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
);
  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic             dir;
  logic [WIDTH-1:0] par_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             overrun_clr;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output ser_in, ser_valid, frame_start, dir, out_ready, overrun_clr,
    input  par_out, out_valid, overrun, bit_cnt
  );

  modport slave (
    input  ser_in, ser_valid, frame_start, dir, out_ready, overrun_clr,
    output par_out, out_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/usr_out_buf.sv
// One-entry valid/ready holding register for completed words, with sticky overrun.
// Ports: i_clk, i_clr_n (sync active-low), i_done/i_word (completed word strobe),
//        i_ready (consumer accept), i_ovr_clr (clear overrun),
//        o_data/o_valid (buffered word), o_overrun (a completed word was dropped).
module usr_out_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_done,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_xfer;
  logic             w_drop;

  assign w_xfer = r_valid & i_ready;
  // Buffer full and not draining this edge: the new word has nowhere to go.
  assign w_drop = i_done & r_valid & ~i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_done && !w_drop) begin
        // Covers both an empty buffer and a same-edge transfer (no bubble).
        r_data  <= i_word;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      // A new drop wins over a coincident clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/usr_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH bits (MSB- or LSB-first) into a word
// and hands completed words to a one-entry valid/ready buffer.
// Ports: clk, clr_n (sync active-low reset), bus (usr_deserializer_if.slave):
//        serial side ser_in/ser_valid/frame_start/dir, parallel side
//        par_out/out_valid/out_ready, overrun/overrun_clr, bit_cnt.
module usr_deserializer
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input logic               clk,
  input logic               clr_n,
  usr_deserializer_if.slave bus
);

  usr_state_e       r_state;
  usr_state_e       w_state_d;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_dir_lat;
  logic             w_dir_d;
  logic             w_done;
  logic [WIDTH-1:0] w_par_out;
  logic             w_out_valid;
  logic             w_overrun;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b,
                                                input logic d);
    logic [WIDTH-1:0] res;
    if (d == DIR_LSB_FIRST) begin
      res = {b, s[WIDTH-1:1]};
    end else begin
      res = {s[WIDTH-2:0], b};
    end
    return res;
  endfunction

  always_comb begin
    w_state_d = r_state;
    w_sreg_d  = r_sreg;
    w_cnt_d   = r_cnt;
    w_dir_d   = r_dir_lat;
    w_done    = 1'b0;
    if (bus.ser_valid) begin
      if (bus.frame_start || r_state == ST_IDLE) begin
        // First bit of a word (fresh or resync): direction is sampled only here.
        // Stale sreg contents are shifted out before the word completes.
        w_dir_d   = bus.dir;
        w_sreg_d  = shift_in(r_sreg, bus.ser_in, bus.dir);
        w_cnt_d   = CNT_W'(1);
        w_state_d = ST_RECV;
      end else begin
        w_sreg_d = shift_in(r_sreg, bus.ser_in, r_dir_lat);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_done    = 1'b1;
          w_cnt_d   = '0;
          w_state_d = ST_IDLE;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state   <= ST_IDLE;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_dir_lat <= DIR_MSB_FIRST;
    end else begin
      r_state   <= w_state_d;
      r_sreg    <= w_sreg_d;
      r_cnt     <= w_cnt_d;
      r_dir_lat <= w_dir_d;
    end
  end

  usr_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .i_clk     (clk),
    .i_clr_n   (clr_n),
    .i_done    (w_done),
    .i_word    (w_sreg_d),
    .i_ready   (bus.out_ready),
    .i_ovr_clr (bus.overrun_clr),
    .o_data    (w_par_out),
    .o_valid   (w_out_valid),
    .o_overrun (w_overrun)
  );

  assign bus.par_out   = w_par_out;
  assign bus.out_valid = w_out_valid;
  assign bus.overrun   = w_overrun;
  assign bus.bit_cnt   = r_cnt;

endmodule

// File: tb/tb_usr_deserializer.sv
// Self-checking bench for usr_deserializer: directed vector table, hand-written corner
// sequences and a randomized phase, all checked every cycle against a queue-based model.
module tb_usr_deserializer;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  logic clk;
  logic clr_n;

  usr_deserializer_if #(.WIDTH(W), .CNT_W(CW)) u_if ();

  usr_deserializer #(
    .WIDTH (W),
    .CNT_W (CW)
  ) u_dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: bits of the word in arrival order plus buffer state.
  bit          m_bits[$];
  bit          m_dir;
  logic [15:0] m_data;
  bit          m_valid;
  bit          m_ovr;

  typedef struct {
    logic [15:0] word;
    logic        d;
    logic        gap;
    logic        tog;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] build_word(input bit d);
    logic [15:0] w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (d) w = w | (16'(m_bits[i]) << i);
      else   w = w | (16'(m_bits[i]) << (W - 1 - i));
    end
    return w;
  endfunction

  // Advance the model using the inputs the DUT sees at the coming edge.
  task automatic model_step();
    bit          done = 0;
    logic [15:0] word = '0;
    if (!clr_n) begin
      m_bits.delete();
      m_dir = 0; m_data = '0; m_valid = 0; m_ovr = 0;
    end else begin
      if (u_if.ser_valid) begin
        if (u_if.frame_start || m_bits.size() == 0) begin
          m_bits.delete();
          m_dir = u_if.dir;
        end
        m_bits.push_back(u_if.ser_in);
        if (m_bits.size() == W) begin
          word = build_word(m_dir);
          done = 1;
          m_bits.delete();
        end
      end
      if (done && m_valid && !u_if.out_ready) begin
        m_ovr = 1;
      end else begin
        if (u_if.overrun_clr) m_ovr = 0;
        if (done) begin
          m_data = word; m_valid = 1;
        end else if (m_valid && u_if.out_ready) begin
          m_valid = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_par_out", u_if.par_out, m_data);
    chk("m_out_valid", u_if.out_valid, m_valid);
    chk("m_overrun", u_if.overrun, m_ovr);
    chk("m_bit_cnt", u_if.bit_cnt, m_bits.size());
  endtask

  task automatic send_word(input logic [15:0] w, input logic d, input logic gap,
                           input logic tog, input logic fs, input int first, input int last);
    for (int i = first; i < last; i++) begin
      if (gap) begin
        repeat ($urandom_range(0, 2)) begin
          u_if.ser_valid = 1'b0;
          u_if.ser_in    = 1'($urandom);
          u_if.dir       = 1'($urandom);
          tick();
        end
      end
      u_if.ser_valid   = 1'b1;
      u_if.frame_start = fs && (i == first);
      u_if.ser_in      = d ? w[i] : w[15-i];
      u_if.dir         = (tog && i > first) ? ~d : d;
      tick();
    end
    u_if.ser_valid   = 1'b0;
    u_if.frame_start = 1'b0;
    u_if.ser_in      = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 1'b0, 16'hA5C3};
    vecs[1] = '{16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234};
    vecs[2] = '{16'hA5C3, 1'b0, 1'b1, 1'b0, 16'hA5C3};
    vecs[3] = '{16'h8001, 1'b1, 1'b1, 1'b1, 16'h8001};
    vecs[4] = '{16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[5] = '{16'h8000, 1'b1, 1'b0, 1'b0, 16'h8000};

    clr_n            = 1'b0;
    u_if.ser_in      = 1'b0;
    u_if.ser_valid   = 1'b0;
    u_if.frame_start = 1'b0;
    u_if.dir         = 1'b0;
    u_if.out_ready   = 1'b1;
    u_if.overrun_clr = 1'b0;
    tick();
    tick();
    chk("rst_par_out", u_if.par_out, 16'h0);
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_overrun", u_if.overrun, 0);
    chk("rst_bit_cnt", u_if.bit_cnt, 0);
    clr_n = 1'b1;
    tick();

    // Vector table: one word each, consumer always ready.
    foreach (vecs[k]) begin
      send_word(vecs[k].word, vecs[k].d, vecs[k].gap, vecs[k].tog, 1'b0, 0, 16);
      chk("tbl_word", u_if.par_out, vecs[k].exp);
      chk("tbl_valid", u_if.out_valid, 1);
      tick();
      chk("tbl_pulse", u_if.out_valid, 0);
    end

    // Stall then overrun: second word is dropped.
    u_if.out_ready = 1'b0;
    send_word(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16);
    send_word(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16);
    chk("ovr_word", u_if.par_out, 16'h0001);
    chk("ovr_valid", u_if.out_valid, 1);
    chk("ovr_flag", u_if.overrun, 1);
    u_if.overrun_clr = 1'b1;
    tick();
    u_if.overrun_clr = 1'b0;
    chk("ovr_clr", u_if.overrun, 0);
    u_if.out_ready = 1'b1;
    tick();
    chk("ovr_drain", u_if.out_valid, 0);

    // Resync: frame_start on the 9th bit restarts the word.
    send_word(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8);
    send_word(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
    chk("sync_cnt", u_if.bit_cnt, 1);
    send_word(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1, 16);
    chk("sync_word", u_if.par_out, 16'hBEEF);
    chk("sync_valid", u_if.out_valid, 1);
    tick();

    // Completion coinciding with a transfer: no bubble, no overrun.
    u_if.out_ready = 1'b0;
    send_word(16'h3C3C, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16);
    send_word(16'h9669, 1'b1, 1'b0, 1'b0, 1'b0, 0, 15);
    chk("pass_hold", u_if.par_out, 16'h3C3C);
    u_if.out_ready = 1'b1;
    send_word(16'h9669, 1'b1, 1'b0, 1'b0, 1'b0, 15, 16);
    chk("pass_word", u_if.par_out, 16'h9669);
    chk("pass_valid", u_if.out_valid, 1);
    chk("pass_ovr", u_if.overrun, 0);
    tick();

    // Reset mid-word while a word is buffered.
    u_if.out_ready = 1'b0;
    send_word(16'h7E81, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16);
    send_word(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 7);
    u_if.ser_valid = 1'b1;
    u_if.ser_in    = 1'b1;
    clr_n          = 1'b0;
    tick();
    chk("mrst_par", u_if.par_out, 16'h0);
    chk("mrst_valid", u_if.out_valid, 0);
    chk("mrst_ovr", u_if.overrun, 0);
    chk("mrst_cnt", u_if.bit_cnt, 0);
    clr_n          = 1'b1;
    u_if.ser_valid = 1'b0;
    u_if.out_ready = 1'b1;
    send_word(16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16);
    chk("mrst_word", u_if.par_out, 16'hC0DE);
    tick();

    // Randomized phase; the model checks every cycle.
    for (int blk = 0; blk < 8; blk++) begin
      int thr = (blk % 4) * 30;
      for (int c = 0; c < 500; c++) begin
        clr_n            = ($urandom_range(0, 399) != 0);
        u_if.ser_valid   = ($urandom_range(0, 3) != 0);
        u_if.ser_in      = 1'($urandom);
        u_if.frame_start = ($urandom_range(0, 40) == 0);
        u_if.dir         = 1'($urandom);
        u_if.out_ready   = ($urandom_range(0, 99) < thr);
        u_if.overrun_clr = ($urandom_range(0, 29) == 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
